// File: rtl/axi_dsp_write_channel.sv
// Per-master AXI write-channel dispatcher: routes AW by address slice, steers W
// beats in AW-acceptance order through an outstanding FIFO, merges B responses.
module axi_dsp_write_channel #(
  parameter int unsigned SLV_AMT           = 2,
  parameter int unsigned OUTSTANDING_AMT   = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_BURST_W     = 2,
  parameter int unsigned TRANS_DATA_LEN_W  = 3,
  parameter int unsigned TRANS_DATA_SIZE_W = 3,
  parameter int unsigned TRANS_WR_RESP_W   = 2,
  parameter int unsigned SLV_ID_W          = $clog2(SLV_AMT),
  parameter int unsigned SLV_ID_MSB_IDX    = 30,
  parameter int unsigned SLV_ID_LSB_IDX    = 30
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESETn_i,
  // master AW
  input  logic [TRANS_MST_ID_W-1:0]              m_AWID_i,
  input  logic [ADDR_WIDTH-1:0]                  m_AWADDR_i,
  input  logic [TRANS_BURST_W-1:0]               m_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]            m_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]           m_AWSIZE_i,
  input  logic                                   m_AWVALID_i,
  output logic                                   m_AWREADY_o,
  // master W
  input  logic [DATA_WIDTH-1:0]                  m_WDATA_i,
  input  logic                                   m_WLAST_i,
  input  logic                                   m_WVALID_i,
  output logic                                   m_WREADY_o,
  // master B
  output logic [TRANS_MST_ID_W-1:0]              m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]             m_BRESP_o,
  output logic                                   m_BVALID_o,
  input  logic                                   m_BREADY_i,
  // slave-arbiter AW
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_AWID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]          sa_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               sa_AWBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]    sa_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]   sa_AWSIZE_o,
  output logic [SLV_AMT-1:0]                     sa_AWVALID_o,
  input  logic [SLV_AMT-1:0]                     sa_AWREADY_i,
  output logic [SLV_AMT-1:0]                     sa_AW_outst_full_o,
  // slave-arbiter W
  output logic [DATA_WIDTH*SLV_AMT-1:0]          sa_WDATA_o,
  output logic [SLV_AMT-1:0]                     sa_WLAST_o,
  output logic [SLV_AMT-1:0]                     sa_WVALID_o,
  input  logic [SLV_AMT-1:0]                     sa_WREADY_i,
  output logic [SLV_AMT-1:0]                     sa_WDATA_sel_o,
  // slave-arbiter B
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]     sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                     sa_BVALID_i,
  output logic [SLV_AMT-1:0]                     sa_BREADY_o
);

  localparam int unsigned SEL_W   = (SLV_ID_W > 0) ? SLV_ID_W : 1;
  localparam int unsigned SLICE_W = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
  localparam int unsigned PTR_W   = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int unsigned CNT_W   = $clog2(OUTSTANDING_AMT + 1);

  logic [SEL_W-1:0]   r_fifo [OUTSTANDING_AMT];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [SLICE_W-1:0] w_addr_slice;
  logic [SEL_W-1:0]   w_aw_sel;
  logic [SEL_W-1:0]   w_head;
  logic [SLV_AMT-1:0] w_aw_onehot;
  logic [SLV_AMT-1:0] w_head_onehot;
  logic [SLV_AMT-1:0] w_b_win;
  logic               w_b_found;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_full  = (r_count == CNT_W'(OUTSTANDING_AMT));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // Out-of-range slave IDs fold onto the last slave
  assign w_addr_slice = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
  always_comb begin
    if (32'(w_addr_slice) >= SLV_AMT) w_aw_sel = SEL_W'(SLV_AMT - 1);
    else                              w_aw_sel = SEL_W'(w_addr_slice);
  end

  always_comb begin
    w_aw_onehot   = '0;
    w_head_onehot = '0;
    for (int unsigned k = 0; k < SLV_AMT; k++) begin
      w_aw_onehot[k]   = (SEL_W'(k) == w_aw_sel);
      w_head_onehot[k] = (SEL_W'(k) == w_head) & ~w_empty;
    end
  end

  // AW routing
  assign sa_AWID_o          = {SLV_AMT{m_AWID_i}};
  assign sa_AWADDR_o        = {SLV_AMT{m_AWADDR_i}};
  assign sa_AWLEN_o         = {SLV_AMT{m_AWLEN_i}};
  assign sa_AWSIZE_o        = {SLV_AMT{m_AWSIZE_i}};
  assign sa_AWBURST_o       = m_AWBURST_i;
  assign sa_AWVALID_o       = w_aw_onehot & {SLV_AMT{m_AWVALID_i & ~w_full}};
  assign m_AWREADY_o        = (|(sa_AWREADY_i & w_aw_onehot)) & ~w_full;
  assign sa_AW_outst_full_o = {SLV_AMT{w_full}};

  // W routing follows the FIFO head
  assign sa_WDATA_o     = {SLV_AMT{m_WDATA_i}};
  assign sa_WVALID_o    = w_head_onehot & {SLV_AMT{m_WVALID_i}};
  assign sa_WLAST_o     = w_head_onehot & {SLV_AMT{m_WLAST_i}};
  assign sa_WDATA_sel_o = w_head_onehot;
  assign m_WREADY_o     = |(sa_WREADY_i & w_head_onehot);

  assign w_push = m_AWVALID_i & m_AWREADY_o;
  assign w_pop  = m_WVALID_i & m_WREADY_o & m_WLAST_i;

  // Outstanding-AW FIFO
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_aw_sel;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // B merge: lowest valid index wins
  always_comb begin
    w_b_win   = '0;
    w_b_found = 1'b0;
    m_BID_o   = '0;
    m_BRESP_o = '0;
    for (int unsigned k = 0; k < SLV_AMT; k++) begin
      if (!w_b_found && sa_BVALID_i[k]) begin
        w_b_found  = 1'b1;
        w_b_win[k] = 1'b1;
        m_BID_o    = sa_BID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        m_BRESP_o  = sa_BRESP_i[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
      end
    end
  end

  assign m_BVALID_o  = |sa_BVALID_i;
  assign sa_BREADY_o = w_b_win & {SLV_AMT{m_BREADY_i}};

endmodule

// File: tb/tb_axi_dsp_write_channel.sv
// Directed self-checking bench for axi_dsp_write_channel (2 slaves, depth 8).
module tb_axi_dsp_write_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  m_AWID;
  logic [31:0] m_AWADDR;
  logic [1:0]  m_AWBURST;
  logic [2:0]  m_AWLEN;
  logic [2:0]  m_AWSIZE;
  logic        m_AWVALID;
  logic        m_AWREADY;
  logic [31:0] m_WDATA;
  logic        m_WLAST;
  logic        m_WVALID;
  logic        m_WREADY;
  logic [4:0]  m_BID;
  logic [1:0]  m_BRESP;
  logic        m_BVALID;
  logic        m_BREADY;
  logic [9:0]  sa_AWID;
  logic [63:0] sa_AWADDR;
  logic [1:0]  sa_AWBURST;
  logic [5:0]  sa_AWLEN;
  logic [5:0]  sa_AWSIZE;
  logic [1:0]  sa_AWVALID;
  logic [1:0]  sa_AWREADY;
  logic [1:0]  sa_full;
  logic [63:0] sa_WDATA;
  logic [1:0]  sa_WLAST;
  logic [1:0]  sa_WVALID;
  logic [1:0]  sa_WREADY;
  logic [1:0]  sa_WSEL;
  logic [9:0]  sa_BID;
  logic [3:0]  sa_BRESP;
  logic [1:0]  sa_BVALID;
  logic [1:0]  sa_BREADY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_dsp_write_channel dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .m_AWID_i(m_AWID), .m_AWADDR_i(m_AWADDR), .m_AWBURST_i(m_AWBURST),
    .m_AWLEN_i(m_AWLEN), .m_AWSIZE_i(m_AWSIZE), .m_AWVALID_i(m_AWVALID),
    .m_AWREADY_o(m_AWREADY),
    .m_WDATA_i(m_WDATA), .m_WLAST_i(m_WLAST), .m_WVALID_i(m_WVALID), .m_WREADY_o(m_WREADY),
    .m_BID_o(m_BID), .m_BRESP_o(m_BRESP), .m_BVALID_o(m_BVALID), .m_BREADY_i(m_BREADY),
    .sa_AWID_o(sa_AWID), .sa_AWADDR_o(sa_AWADDR), .sa_AWBURST_o(sa_AWBURST),
    .sa_AWLEN_o(sa_AWLEN), .sa_AWSIZE_o(sa_AWSIZE), .sa_AWVALID_o(sa_AWVALID),
    .sa_AWREADY_i(sa_AWREADY), .sa_AW_outst_full_o(sa_full),
    .sa_WDATA_o(sa_WDATA), .sa_WLAST_o(sa_WLAST), .sa_WVALID_o(sa_WVALID),
    .sa_WREADY_i(sa_WREADY), .sa_WDATA_sel_o(sa_WSEL),
    .sa_BID_i(sa_BID), .sa_BRESP_i(sa_BRESP), .sa_BVALID_i(sa_BVALID), .sa_BREADY_o(sa_BREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m_AWID = 5'd3; m_AWADDR = 32'h0; m_AWBURST = 2'd1; m_AWLEN = 3'd2; m_AWSIZE = 3'd2;
    m_AWVALID = 1'b1; m_WDATA = 32'h0; m_WLAST = 1'b1; m_WVALID = 1'b1; m_BREADY = 1'b1;
    sa_AWREADY = 2'b11; sa_WREADY = 2'b11;
    sa_BID = '0; sa_BRESP = '0; sa_BVALID = 2'b00;

    // In reset: AW path live, W path and full flag forced quiet
    #3;
    check("rst_awvalid", sa_AWVALID, 2'b01);
    check("rst_full", sa_full, 2'b00);
    check("rst_wready", m_WREADY, 1'b0);
    check("rst_wvalid", sa_WVALID, 2'b00);
    check("rst_wsel", sa_WSEL, 2'b00);
    check("rst_awid_rep", sa_AWID, {5'd3, 5'd3});

    @(negedge clk);
    rst_n = 1'b1; m_WVALID = 1'b0;
    // AW to slave 0 then slave 1
    m_AWADDR = 32'h0000_0000; #1;
    check("aw0_valid", sa_AWVALID, 2'b01);
    check("aw0_ready", m_AWREADY, 1'b1);
    tick();
    m_AWADDR = 32'h4000_001E; #1;
    check("aw1_valid", sa_AWVALID, 2'b10);
    check("aw1_ready", m_AWREADY, 1'b1);
    check("aw1_addr_rep", sa_AWADDR, {32'h4000_001E, 32'h4000_001E});
    tick();

    // W: non-last beat keeps head, last beats pop in order
    m_AWVALID = 1'b0; m_WVALID = 1'b1; m_WDATA = 32'd100; m_WLAST = 1'b0; #1;
    check("w0a_valid", sa_WVALID, 2'b01);
    check("w0a_sel", sa_WSEL, 2'b01);
    check("w0a_data", sa_WDATA, {32'd100, 32'd100});
    tick();
    m_WLAST = 1'b1; #1;
    check("w0b_valid", sa_WVALID, 2'b01);
    check("w0b_wlast", sa_WLAST, 2'b01);
    check("w0b_ready", m_WREADY, 1'b1);
    tick();
    m_WDATA = 32'd200; #1;
    check("w1_valid", sa_WVALID, 2'b10);
    check("w1_sel", sa_WSEL, 2'b10);
    tick();
    m_WVALID = 1'b0; #1;
    check("drained_sel", sa_WSEL, 2'b00);
    check("drained_wready", m_WREADY, 1'b0);

    // Fill all 8 entries (pointers wrap from 2)
    for (int i = 0; i < 8; i++) begin
      m_AWVALID = 1'b1;
      m_AWADDR = i[0] ? 32'h4000_0000 : 32'h0000_0000; #1;
      check("fill_ready", m_AWREADY, 1'b1);
      tick();
    end
    m_AWADDR = 32'h4000_0000; #1;
    check("full_flag", sa_full, 2'b11);
    check("full_awready", m_AWREADY, 1'b0);
    check("full_awvalid", sa_AWVALID, 2'b00);

    // Full with a pop in the same cycle: AW still blocked
    m_WVALID = 1'b1; m_WLAST = 1'b1; #1;
    check("fullpop_awready", m_AWREADY, 1'b0);
    check("fullpop_wvalid", sa_WVALID, 2'b01);
    tick();
    m_WVALID = 1'b0; #1;
    check("reopen_full", sa_full, 2'b00);
    check("reopen_awready", m_AWREADY, 1'b1);
    check("reopen_awvalid", sa_AWVALID, 2'b10);
    #1 m_AWVALID = 1'b0;
    tick();

    // Simultaneous push and pop at count 7: count stays 7
    m_AWVALID = 1'b1; m_AWADDR = 32'h0; m_WVALID = 1'b1; #1;
    check("pp_awready", m_AWREADY, 1'b1);
    check("pp_wsel", sa_WSEL, 2'b10);
    tick();
    m_AWVALID = 1'b0; m_WVALID = 1'b0; #1;
    check("pp_not_full", sa_full, 2'b00);

    // Drain remaining 7 in acceptance order
    for (int i = 2; i < 9; i++) begin
      m_WVALID = 1'b1; #1;
      check("drain_sel", sa_WSEL, (i == 8 || !i[0]) ? 2'b01 : 2'b10);
      tick();
    end
    m_WVALID = 1'b0; #1;
    check("drain_empty", sa_WSEL, 2'b00);

    // W arriving with its own AW stalls until the AW lands
    m_AWVALID = 1'b1; m_AWADDR = 32'h4000_0000; m_WVALID = 1'b1; m_WLAST = 1'b1; #1;
    check("same_wready", m_WREADY, 1'b0);
    check("same_wvalid", sa_WVALID, 2'b00);
    check("same_awready", m_AWREADY, 1'b1);
    tick();
    m_AWVALID = 1'b0; #1;
    check("after_wready", m_WREADY, 1'b1);
    check("after_wvalid", sa_WVALID, 2'b10);
    tick();
    m_WVALID = 1'b0;

    // B merge
    sa_BVALID = 2'b10; sa_BID = {5'd10, 5'd0}; sa_BRESP = {2'd2, 2'd0}; #1;
    check("b1_valid", m_BVALID, 1'b1);
    check("b1_id", m_BID, 5'd10);
    check("b1_resp", m_BRESP, 2'd2);
    check("b1_ready", sa_BREADY, 2'b10);
    tick();
    sa_BID = {5'd11, 5'd0}; #1;
    check("b2_id", m_BID, 5'd11);
    check("b2_ready", sa_BREADY, 2'b10);
    tick();
    sa_BVALID = 2'b11; sa_BRESP = {2'd2, 2'd1}; #1;
    check("b3_id", m_BID, 5'd0);
    check("b3_resp", m_BRESP, 2'd1);
    check("b3_ready", sa_BREADY, 2'b01);
    m_BREADY = 1'b0; #1;
    check("b3_nobready", sa_BREADY, 2'b00);
    tick();
    sa_BVALID = 2'b00; m_BREADY = 1'b1; #1;
    check("b_none_valid", m_BVALID, 1'b0);
    check("b_none_id", m_BID, 5'd0);

    // Slave 1 AW not ready: no push until it rises
    sa_AWREADY = 2'b01; m_AWVALID = 1'b1; m_AWADDR = 32'h4000_0000; #1;
    check("nr_awready", m_AWREADY, 1'b0);
    check("nr_awvalid", sa_AWVALID, 2'b10);
    tick();
    #1;
    check("nr_nopush", sa_WSEL, 2'b00);
    sa_AWREADY = 2'b11; #1;
    check("nr_rise_ready", m_AWREADY, 1'b1);
    tick();
    m_AWVALID = 1'b0; #1;
    check("nr_pushed", sa_WSEL, 2'b10);

    // Reset with an entry outstanding discards it
    m_WVALID = 1'b1; rst_n = 1'b0; #1;
    check("mid_rst_sel", sa_WSEL, 2'b00);
    check("mid_rst_wready", m_WREADY, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; m_WVALID = 1'b0; #1;
    check("post_rst_sel", sa_WSEL, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
